fft_input_loader: RTL and testbench

Upstream stage of the 256-point radix-4 FFT `top_level`. It accepts a serial stream of 16-bit samples over a valid/ready handshake and buffers one full frame of N samples in four quarter-frame banks. It then replays the frame into `top_level`'s parallel load port (`prepare_data`, `input_d0..3`) for MEM_HEIGHT cycles while holding the FFT's `rst_top`. It releases `rst_top` to start the transform and waits for the FFT's done pulse before accepting the next frame.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_input_loader_sample_bank.sv | 39 +++
 rtl/fft_input_loader.sv | 127 ++++++++++++
 tb/tb_fft_input_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and state type for the FFT input loader and the
// radix-4 FFT core it feeds.
package fft_pkg;

  localparam int DATA_BIT   = 16;
  localparam int N          = 256;
  localparam int MEM_HEIGHT = N / 4;
  localparam int ADDR_BIT   = 6;
  localparam int INDEX_BIT  = ADDR_BIT + 2;
  localparam int NUM_BANKS  = 4;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Quarter-frame bank that holds sample index i (top two index bits).
  function automatic logic [1:0] bank_of(input logic [INDEX_BIT-1:0] i);
    return i[INDEX_BIT-1 -: 2];
  endfunction

  // Word address inside the bank for sample index i.
  function automatic logic [ADDR_BIT-1:0] addr_of(input logic [INDEX_BIT-1:0] i);
    return i[ADDR_BIT-1:0];
  endfunction

endpackage

// File: rtl/fft_input_loader_sample_bank.sv
// One quarter-frame sample store: synchronous write port and a registered
// read port. The array itself carries no reset; only the read register does,
// so the loader outputs come up as zero.
module sample_bank
  import fft_pkg::*;
#(
  parameter int W     = DATA_BIT,
  parameter int DEPTH = MEM_HEIGHT,
  parameter int AW    = ADDR_BIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Storage write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; holds its last word when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// Collects a serial frame of N samples into four quarter-frame banks, then
// replays it onto the FFT parallel load port while holding the FFT in reset,
// releases the FFT and waits for its done pulse before the next frame.
module fft_input_loader
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_BIT-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                fft_done,
  output logic                prepare_data,
  output logic                rst_top,
  output logic [DATA_BIT-1:0] input_d0,
  output logic [DATA_BIT-1:0] input_d1,
  output logic [DATA_BIT-1:0] input_d2,
  output logic [DATA_BIT-1:0] input_d3,
  output logic                busy
);

  state_t                 state_reg;
  logic [INDEX_BIT-1:0]   index_reg;
  logic [ADDR_BIT-1:0]    k_reg;
  logic                   transfer;
  logic                   rd_en;
  logic [DATA_BIT-1:0]    bank_data [NUM_BANKS];

  // s_ready is only ever high in FILL, so it alone qualifies a transfer.
  assign transfer = s_valid && s_ready;
  assign rd_en    = (state_reg == LOAD);

  // Four banks, selected by the top index bits on write and read in
  // lock-step at address k during LOAD.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic wr_en;
      assign wr_en = transfer && (bank_of(index_reg) == 2'(gi));

      sample_bank #(
        .W     (DATA_BIT),
        .DEPTH (MEM_HEIGHT),
        .AW    (ADDR_BIT)
      ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (addr_of(index_reg)),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (k_reg),
        .rd_data (bank_data[gi])
      );
    end
  endgenerate

  // Bank read registers are the output registers for the data words.
  assign input_d0 = bank_data[0];
  assign input_d1 = bank_data[1];
  assign input_d2 = bank_data[2];
  assign input_d3 = bank_data[3];

  // Frame sequencer: state, counters and all registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      index_reg    <= '0;
      k_reg        <= '0;
      s_ready      <= 1'b0;
      prepare_data <= 1'b0;
      rst_top      <= 1'b1;
      busy         <= 1'b0;
    end else begin
      // Delayed by one cycle to line up with the bank read latency.
      prepare_data <= (state_reg == LOAD);

      case (state_reg)
        FILL: begin
          s_ready <= 1'b1;
          rst_top <= 1'b1;
          busy    <= 1'b0;
          if (transfer) begin
            index_reg <= index_reg + 1'b1;
            if (index_reg == INDEX_BIT'(N - 1)) begin
              state_reg <= LOAD;
              k_reg     <= '0;
              s_ready   <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end

        LOAD: begin
          s_ready <= 1'b0;
          rst_top <= 1'b1;
          busy    <= 1'b1;
          k_reg   <= k_reg + 1'b1;
          if (k_reg == ADDR_BIT'(MEM_HEIGHT - 1)) begin
            state_reg <= RUN;
          end
        end

        RUN: begin
          s_ready <= 1'b0;
          rst_top <= 1'b0;
          busy    <= 1'b1;
          if (fft_done) begin
            state_reg <= FILL;
            index_reg <= '0;
            s_ready   <= 1'b1;
            rst_top   <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= FILL;
          index_reg <= '0;
          s_ready   <= 1'b0;
          rst_top   <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomised bench for fft_input_loader with a frame-level reference model
// and a scoreboard-driven load-port monitor.
module tb_fft_input_loader;
  import fft_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DATA_BIT-1:0] s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic                fft_done = 1'b0;
  logic                prepare_data;
  logic                rst_top;
  logic [DATA_BIT-1:0] input_d0, input_d1, input_d2, input_d3;
  logic                busy;

  int checks = 0;
  int errors = 0;

  logic [63:0]         exp_q [$];
  logic [DATA_BIT-1:0] frame [N];
  int                  run_len = 0;
  int                  beats_total = 0;

  fft_input_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .fft_done     (fft_done),
    .prepare_data (prepare_data),
    .rst_top      (rst_top),
    .input_d0     (input_d0),
    .input_d1     (input_d1),
    .input_d2     (input_d2),
    .input_d3     (input_d3),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: beat k of a frame carries samples k, k+N/4, k+N/2, k+3N/4.
  task automatic push_expected();
    for (int k = 0; k < MEM_HEIGHT; k++) begin
      exp_q.push_back({frame[k], frame[MEM_HEIGHT + k],
                       frame[2*MEM_HEIGHT + k], frame[3*MEM_HEIGHT + k]});
    end
  endtask

  // Monitor: every load beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else if (prepare_data) begin
      run_len++;
      beats_total++;
      chk("rst_top_during_load", {63'd0, rst_top}, 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {input_d0, input_d1, input_d2, input_d3}, 64'hx);
      end else begin
        chk("load_beat", {input_d0, input_d1, input_d2, input_d3}, exp_q.pop_front());
      end
      $display("beat %0d: d=%0d %0d %0d %0d", run_len - 1, input_d0, input_d1, input_d2, input_d3);
    end else if (run_len > 0) begin
      chk("load_length", 64'(run_len), 64'(MEM_HEIGHT));
      chk("rst_top_falls_with_prepare", {63'd0, rst_top}, 64'd0);
      run_len = 0;
    end
  end

  // Drive one frame from frame[]; gap_pct is the chance s_valid is low,
  // spurious_at pulses fft_done once that many samples have transferred.
  task automatic send_frame(input int gap_pct, input int spurious_at);
    int i = 0;
    int cyc = 0;
    bit pulsed = 0;
    while (i < N && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      fft_done = 1'b0;
      if (!pulsed && spurious_at >= 0 && i == spurious_at) begin
        fft_done = 1'b1;
        pulsed = 1;
      end
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = frame[i];
      if (s_valid && s_ready) begin
        i++;
        if (i == N) push_expected();
      end
    end
    if (i < N) chk("fill_timeout", 64'(i), 64'(N));
    @(negedge clk);
    fft_done = 1'b0;
    s_valid  = 1'b0;
    chk("s_ready_after_last", {63'd0, s_ready}, 64'd0);
    chk("busy_after_last", {63'd0, busy}, 64'd1);
    $display("frame sent: first=%0d last=%0d cycles=%0d", frame[0], frame[N-1], cyc);
  endtask

  // Wait for the load burst to finish; optionally pulse fft_done mid-load.
  task automatic wait_load(input int done_at_beat);
    int seen = 0;
    int cyc = 0;
    bit fell = 0;
    while (!fell && cyc < 400) begin
      @(negedge clk);
      cyc++;
      fft_done = 1'b0;
      if (prepare_data) begin
        seen++;
        if (seen == done_at_beat) fft_done = 1'b1;
      end else if (seen > 0) begin
        fell = 1;
      end
    end
    fft_done = 1'b0;
    chk("load_completed", {63'd0, fell}, 64'd1);
    chk("run_rst_top", {63'd0, rst_top}, 64'd0);
    chk("run_busy", {63'd0, busy}, 64'd1);
    chk("run_s_ready", {63'd0, s_ready}, 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    chk("done_rst_top", {63'd0, rst_top}, 64'd1);
    chk("done_s_ready", {63'd0, s_ready}, 64'd1);
    chk("done_busy", {63'd0, busy}, 64'd0);
    $display("fft_done pulse handled");
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_s_ready", {63'd0, s_ready}, 64'd0);
    chk("reset_prepare", {63'd0, prepare_data}, 64'd0);
    chk("reset_rst_top", {63'd0, rst_top}, 64'd1);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_data", {input_d0, input_d1, input_d2, input_d3}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_release", {63'd0, s_ready}, 64'd1);

    // Ramp frame, no gaps
    for (int i = 0; i < N; i++) frame[i] = DATA_BIT'(i);
    send_frame(0, -1);
    wait_load(-1);
    pulse_done();

    // Same ramp with ~50% gaps
    send_frame(50, -1);
    wait_load(-1);
    pulse_done();

    // Second-frame ramp 1000.., spurious done during fill and load
    for (int i = 0; i < N; i++) frame[i] = DATA_BIT'(1000 + i);
    send_frame(30, 100);
    wait_load(10);

    // s_valid with changing data during RUN must not transfer
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = DATA_BIT'($urandom);
      chk("run_ignores_valid", {63'd0, s_ready}, 64'd0);
    end
    s_valid = 1'b0;
    pulse_done();

    // Random frame: must start at index 0 despite RUN traffic
    for (int i = 0; i < N; i++) frame[i] = DATA_BIT'($urandom);
    send_frame(20, -1);
    wait_load(-1);
    pulse_done();

    // Random frame interrupted by reset at load beat 20
    for (int i = 0; i < N; i++) frame[i] = DATA_BIT'($urandom);
    send_frame(10, -1);
    begin
      int seen = 0;
      int cyc = 0;
      while (seen < 20 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (prepare_data) seen++;
      end
      chk("reached_beat20", 64'(seen), 64'd20);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_prepare", {63'd0, prepare_data}, 64'd0);
    chk("async_reset_rst_top", {63'd0, rst_top}, 64'd1);
    chk("async_reset_s_ready", {63'd0, s_ready}, 64'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("s_ready_held_in_reset", {63'd0, s_ready}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_mid_reset", {63'd0, s_ready}, 64'd1);
    chk("no_prepare_after_reset", {63'd0, prepare_data}, 64'd0);

    // A full new frame is needed; any earlier beat hits an empty scoreboard
    for (int i = 0; i < N; i++) frame[i] = DATA_BIT'($urandom);
    send_frame(40, -1);
    wait_load(-1);
    pulse_done();

    chk("total_beats", 64'(beats_total), 64'(5 * MEM_HEIGHT + 20));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
